ser_frame_arbiter: RTL and testbench

//  Round-robin scheduler sharing the single serial line into the serial port-demux datapath among 4 requesters.

---
 rtl/ser_frame_arbiter_if.sv | 30 +++
 rtl/ser_frame_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ser_frame_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ser_frame_arbiter_if.sv
// Bus bundle between the frame arbiter and its requesters and receiver.
interface ser_frame_arbiter_if #(
    parameter int unsigned CNT_W = 4
);
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = (1 << CNT_W) - 1;

    logic                      clkEn;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*CNT_W-1:0]    cnt_flat;
    logic [N_REQ*DATA_W-1:0]   data_flat;
    logic                      done;
    logic                      ser_out;
    logic [N_REQ-1:0]          gnt;
    logic [N_REQ-1:0]          ack;
    logic                      err;
    logic                      busy;

    // Requester / receiver side
    modport master (
        output clkEn, req, cnt_flat, data_flat, done,
        input  ser_out, gnt, ack, err, busy
    );

    // Arbiter side
    modport slave (
        input  clkEn, req, cnt_flat, data_flat, done,
        output ser_out, gnt, ack, err, busy
    );
endinterface

// File: rtl/ser_frame_arbiter.sv
// Round-robin arbiter that serializes one frame (start, port, count, data)
// per grant onto a shared serial line and waits for the receiver's done.
module ser_frame_arbiter #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    ser_frame_arbiter_if.slave bus
);
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = (1 << CNT_W) - 1;
    localparam int unsigned HDR_W  = 2 + CNT_W;
    localparam int unsigned HIDX_W = $clog2(HDR_W + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_WAIT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         gidx_q, gidx_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic [HIDX_W-1:0]  hidx_q, hidx_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   dcnt_q, dcnt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [TO_W-1:0]    tcnt_q, tcnt_d;
    logic               ser_q, ser_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic [CNT_W-1:0]   cnt_arr [N_REQ];
    logic [DATA_W-1:0]  dat_arr [N_REQ];
    logic [1:0]         win_c;
    logic               win_vld_c;
    logic [1:0]         rr_idx_c;

    // Split the flat request buses into per-requester fields
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_split
        assign cnt_arr[gi] = bus.cnt_flat[gi*CNT_W +: CNT_W];
        assign dat_arr[gi] = bus.data_flat[gi*DATA_W +: DATA_W];
    end

    // Round-robin search starting at the priority pointer
    always_comb begin
        win_vld_c = 1'b0;
        win_c     = ptr_q;
        rr_idx_c  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            rr_idx_c = ptr_q + 2'(k);
            if (!win_vld_c && bus.req[rr_idx_c]) begin
                win_vld_c = 1'b1;
                win_c     = rr_idx_c;
            end
        end
    end

    // Next-state and output logic; everything holds while clkEn is low
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        hdr_d   = hdr_q;
        hidx_d  = hidx_q;
        n_d     = n_q;
        dcnt_d  = dcnt_q;
        data_d  = data_q;
        tcnt_d  = tcnt_q;
        ser_d   = ser_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        err_d   = err_q;
        if (bus.clkEn) begin
            ack_d = '0;
            err_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    ser_d = 1'b1;
                    if (win_vld_c) begin
                        gidx_d         = win_c;
                        gnt_d          = '0;
                        gnt_d[win_c]   = 1'b1;
                        n_d            = cnt_arr[win_c];
                        hdr_d          = {win_c, cnt_arr[win_c]};
                        data_d         = dat_arr[win_c];
                        hidx_d         = '0;
                        ser_d          = 1'b0;
                        state_d        = S_HDR;
                    end
                end
                S_HDR: begin
                    if (hidx_q != HIDX_W'(HDR_W)) begin
                        ser_d  = hdr_q[HDR_W-1];
                        hdr_d  = hdr_q << 1;
                        hidx_d = hidx_q + HIDX_W'(1);
                    end else if (n_q != '0) begin
                        ser_d   = data_q[0];
                        data_d  = data_q >> 1;
                        dcnt_d  = n_q - CNT_W'(1);
                        state_d = S_DATA;
                    end else begin
                        ser_d   = 1'b1;
                        tcnt_d  = '0;
                        state_d = S_WAIT;
                    end
                end
                S_DATA: begin
                    if (dcnt_q != '0) begin
                        ser_d  = data_q[0];
                        data_d = data_q >> 1;
                        dcnt_d = dcnt_q - CNT_W'(1);
                    end else begin
                        ser_d   = 1'b1;
                        tcnt_d  = '0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    ser_d = 1'b1;
                    if (bus.done || (tcnt_q == TO_W'(TIMEOUT - 1))) begin
                        ack_d   = gnt_q;
                        err_d   = !bus.done;
                        gnt_d   = '0;
                        ptr_d   = gidx_q + 2'd1;
                        state_d = S_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TO_W'(1);
                    end
                end
                default: begin
                    ser_d   = 1'b1;
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gidx_q  <= '0;
            ptr_q   <= '0;
            hdr_q   <= '0;
            hidx_q  <= '0;
            n_q     <= '0;
            dcnt_q  <= '0;
            data_q  <= '0;
            tcnt_q  <= '0;
            ser_q   <= 1'b1;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            hdr_q   <= hdr_d;
            hidx_q  <= hidx_d;
            n_q     <= n_d;
            dcnt_q  <= dcnt_d;
            data_q  <= data_d;
            tcnt_q  <= tcnt_d;
            ser_q   <= ser_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ser_out = ser_q;
    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_ser_frame_arbiter.sv
// Directed + randomized bench for ser_frame_arbiter with a frame-level model.
module tb_ser_frame_arbiter;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 64;

    typedef bit bitq_t[$];

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   en_per;
    int   model_ptr;
    int   reraise_port;
    logic cur_exp;
    int   cnt_a [4];
    logic [14:0] dat_a [4];

    ser_frame_arbiter_if #(.CNT_W(CNT_W)) bus ();

    ser_frame_arbiter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < 4; i++) begin
            bus.cnt_flat[i*4 +: 4]    = 4'(cnt_a[i]);
            bus.data_flat[i*15 +: 15] = dat_a[i];
        end
    endtask

    // One enabled clock; frozen clocks in between must hold the line
    task automatic step_en();
        for (int i = 1; i < en_per; i++) begin
            bus.clkEn = 1'b0;
            @(posedge clk);
            #1;
            check("hold_ser", 32'(bus.ser_out), 32'(cur_exp));
        end
        bus.clkEn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Frame as the receiver should see it: start, port MSB first, count MSB first, data LSB first
    function automatic bitq_t build(input int port, input int n, input logic [14:0] d);
        bitq_t q;
        q.push_back(1'b0);
        q.push_back(bit'((port >> 1) & 1));
        q.push_back(bit'(port & 1));
        for (int b = CNT_W - 1; b >= 0; b--) q.push_back(bit'((n >> b) & 1));
        for (int i = 0; i < n; i++) q.push_back(d[i]);
        return q;
    endfunction

    function automatic bitq_t from_vec(input logic [31:0] v, input int len);
        bitq_t q;
        for (int i = len - 1; i >= 0; i--) q.push_back(v[i]);
        return q;
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Grant, serialize, wait for done (or timeout) and ack one frame
    task automatic do_frame(input int port, input bitq_t bits, input int done_dly,
                            input bit expect_to, input bit reraise);
        logic [31:0] oh;
        oh = 32'(1) << port;
        step_en();
        check("start_bit", 32'(bus.ser_out), 32'(bits[0]));
        check("gnt", 32'(bus.gnt), oh);
        check("busy", 32'(bus.busy), 32'd1);
        cur_exp = bits[0];
        bus.req[port] = 1'b0;
        cnt_a[port]   = int'($urandom_range(0, 15));
        dat_a[port]   = 15'($urandom);
        if (reraise_port >= 0) begin
            bus.req[reraise_port] = 1'b1;
            reraise_port = -1;
        end
        pack();
        for (int i = 1; i < bits.size(); i++) begin
            bus.done = 1'($urandom);
            step_en();
            check("frame_bit", 32'(bus.ser_out), 32'(bits[i]));
            check("gnt_held", 32'(bus.gnt), oh);
            check("no_ack", 32'(bus.ack), 32'd0);
            cur_exp = bits[i];
        end
        bus.done = 1'($urandom);
        step_en();
        check("line_idle", 32'(bus.ser_out), 32'd1);
        check("gnt_wait", 32'(bus.gnt), oh);
        cur_exp = 1'b1;
        if (expect_to) begin
            bus.done = 1'b0;
            for (int k = 1; k < TIMEOUT; k++) begin
                step_en();
                check("to_no_ack", 32'(bus.ack), 32'd0);
                check("to_no_err", 32'(bus.err), 32'd0);
            end
            step_en();
            check("to_ack", 32'(bus.ack), oh);
            check("to_err", 32'(bus.err), 32'd1);
        end else begin
            for (int k = 0; k < done_dly; k++) begin
                bus.done = 1'b0;
                step_en();
                check("wait_no_ack", 32'(bus.ack), 32'd0);
            end
            bus.done = 1'b1;
            step_en();
            bus.done = 1'b0;
            check("ack", 32'(bus.ack), oh);
            check("err_low", 32'(bus.err), 32'd0);
        end
        check("gnt_clear", 32'(bus.gnt), 32'd0);
        check("busy_clear", 32'(bus.busy), 32'd0);
        model_ptr = (port + 1) % 4;
        if (reraise) reraise_port = port;
    endtask

    initial begin
        int rr_exp [5];
        int p;
        checks       = 0;
        errors       = 0;
        en_per       = 1;
        model_ptr    = 0;
        reraise_port = -1;
        cur_exp      = 1'b1;
        rr_exp       = '{0, 1, 2, 3, 0};
        rst          = 1'b0;
        bus.clkEn    = 1'b0;
        bus.req      = '0;
        bus.done     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cnt_a[i] = 0;
            dat_a[i] = '0;
        end
        pack();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ser", 32'(bus.ser_out), 32'd1);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;

        // No requests: stays idle
        for (int i = 0; i < 3; i++) begin
            step_en();
            check("idle_gnt", 32'(bus.gnt), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_ser", 32'(bus.ser_out), 32'd1);
        end

        // Single frame, port 1, N=3, data ...101
        cnt_a[1] = 3;
        dat_a[1] = {12'($urandom), 3'b101};
        bus.req  = 4'b0010;
        pack();
        do_frame(1, from_vec(32'b0010011101, 10), 2, 1'b0, 1'b0);

        // Empty frame on port 3
        cnt_a[3] = 0;
        dat_a[3] = 15'($urandom);
        bus.req  = 4'b1000;
        pack();
        do_frame(3, from_vec(32'b0110000, 7), 1, 1'b0, 1'b0);

        // Round-robin with all requesters busy
        for (int i = 0; i < 4; i++) begin
            cnt_a[i] = int'($urandom_range(0, 15));
            dat_a[i] = 15'($urandom);
        end
        bus.req = 4'b1111;
        pack();
        for (int j = 0; j < 5; j++) begin
            p = rr_exp[j];
            do_frame(p, build(p, cnt_a[p], dat_a[p]), int'($urandom_range(0, 3)), 1'b0, 1'b1);
        end
        reraise_port = -1;
        bus.req = '0;
        pack();

        // Enable every third clock, same frame as the single-frame case
        en_per   = 3;
        cnt_a[1] = 3;
        dat_a[1] = {12'($urandom), 3'b101};
        bus.req  = 4'b0010;
        pack();
        do_frame(1, from_vec(32'b0010011101, 10), 2, 1'b0, 1'b0);
        en_per = 1;

        // Timeout on port 2, then pending port 3 is served
        for (int i = 2; i < 4; i++) begin
            cnt_a[i] = int'($urandom_range(0, 15));
            dat_a[i] = 15'($urandom);
        end
        bus.req = 4'b1100;
        pack();
        do_frame(2, build(2, cnt_a[2], dat_a[2]), 0, 1'b1, 1'b0);
        do_frame(3, build(3, cnt_a[3], dat_a[3]), 1, 1'b0, 1'b0);

        // Randomized traffic checked against the frame model
        for (int it = 0; it < 16; it++) begin
            if (bus.req == '0) begin
                bus.req = 4'($urandom_range(1, 15));
                for (int i = 0; i < 4; i++) begin
                    if (bus.req[i]) begin
                        cnt_a[i] = int'($urandom_range(0, 15));
                        dat_a[i] = 15'($urandom);
                    end
                end
                pack();
            end
            en_per = int'($urandom_range(1, 3));
            p = pick(bus.req, model_ptr);
            do_frame(p, build(p, cnt_a[p], dat_a[p]), int'($urandom_range(0, 4)), 1'b0, 1'b0);
        end
        en_per = 1;

        // Asynchronous reset in the middle of the data field
        bus.req = '0;
        pack();
        step_en();
        cnt_a[0] = 15;
        dat_a[0] = 15'($urandom);
        bus.req  = 4'b0001;
        pack();
        step_en();
        check("pre_rst_gnt", 32'(bus.gnt), 32'd1);
        for (int i = 0; i < 9; i++) step_en();
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_ser", 32'(bus.ser_out), 32'd1);
        check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ack", 32'(bus.ack), 32'd0);
        check("mid_rst_err", 32'(bus.err), 32'd0);
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cur_exp = 1'b1;
        step_en();
        check("post_rst_ser", 32'(bus.ser_out), 32'd1);
        check("post_rst_gnt", 32'(bus.gnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
